// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel width and FSM state encodings for the VGA display path.
package vga_pkg;

  localparam int FB_ADDR_W = 13;
  localparam int FB_COL_W  = 7;
  localparam int FB_ROW_W  = 6;
  localparam int PIX_W     = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // Weighted column/row sum a + 2b + c, widened so the later difference wraps to a valid 8-bit signed value.
  function automatic logic [7:0] wsum(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                      input logic [PIX_W-1:0] c);
    return {4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c};
  endfunction

  function automatic logic [7:0] abs8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One entry per column holding {row r-2, row r-1}; asynchronous read, synchronous write at the same column.
module sobel_line_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH = 80,
  parameter int W     = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [FB_COL_W-1:0] addr_i,
  input  logic [W-1:0]        wdata_i,
  output logic [W-1:0]        rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_stream.sv
// Clears the frame buffer, then streams a raster frame through a 3x3 Sobel and writes interior edge magnitudes.
module sobel_stream
  import vga_pkg::*;
#(
  parameter int IMG_W = 80,
  parameter int IMG_H = 60,
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [PIX_W-1:0]     in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [FB_COL_W-1:0] COL_LAST = FB_COL_W'(IMG_W - 1);
  localparam logic [FB_ROW_W-1:0] ROW_LAST = FB_ROW_W'(IMG_H - 1);

  logic [1:0]          state_q, state_d;
  logic [FB_COL_W-1:0] col_q, col_d;
  logic [FB_ROW_W-1:0] row_q, row_d;
  logic                drain_q, drain_d;
  logic                done_q, done_d;

  logic                accept;
  logic                col_end, frame_end;
  logic [7:0]          lb_rd;

  logic [PIX_W-1:0]     p_q [3][3];
  logic                 v0_q, s1_v_q, s2_v_q;
  logic [FB_ADDR_W-1:0] t0_addr_q, t1_addr_q, s2_addr_q;
  logic [7:0]           gx_q, gy_q;
  logic [PIX_W-1:0]     s2_data_q;
  logic [7:0]           mag, mag_sh;

  assign accept    = in_valid && (state_q == RUN);
  assign col_end   = (col_q == COL_LAST);
  assign frame_end = col_end && (row_q == ROW_LAST);

  sobel_line_buffer #(.DEPTH(IMG_W), .W(8)) u_lb (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i({lb_rd[3:0], in_data}),
    .rdata_o(lb_rd)
  );

  // CLEAR and RUN share the raster counters; RUN advances them only on accepted pixels.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          col_d   = '0;
          row_d   = '0;
        end
      end
      CLEAR, RUN: begin
        if (state_q == CLEAR || accept) begin
          if (col_end) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + FB_ROW_W'(1);
          end else begin
            col_d = col_q + FB_COL_W'(1);
          end
          if (frame_end) begin
            state_d = (state_q == CLEAR) ? RUN : DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned y = 0; y < 3; y++) begin
        p_q[y][0] <= p_q[y][1];
        p_q[y][1] <= p_q[y][2];
      end
      p_q[0][2] <= lb_rd[7:4];
      p_q[1][2] <= lb_rd[3:0];
      p_q[2][2] <= in_data;
      t0_addr_q <= {row_q - FB_ROW_W'(1), col_q - FB_COL_W'(1)};
    end
    gx_q      <= wsum(p_q[0][2], p_q[1][2], p_q[2][2]) - wsum(p_q[0][0], p_q[1][0], p_q[2][0]);
    gy_q      <= wsum(p_q[2][0], p_q[2][1], p_q[2][2]) - wsum(p_q[0][0], p_q[0][1], p_q[0][2]);
    t1_addr_q <= t0_addr_q;
  end

  assign mag    = abs8(gx_q) + abs8(gy_q);
  assign mag_sh = mag >> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q      <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
    end else begin
      v0_q   <= accept && (row_q >= FB_ROW_W'(2)) && (col_q >= FB_COL_W'(2));
      s1_v_q <= v0_q;
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_addr_q <= t1_addr_q;
        s2_data_q <= (mag_sh > 8'd15) ? 4'hF : mag_sh[3:0];
      end
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == CLEAR) || (state_q == RUN);
  assign done     = done_q;
  assign wr_en    = (state_q == CLEAR) || s2_v_q;
  assign wr_addr  = (state_q == CLEAR) ? {row_q, col_q} : s2_addr_q;
  assign wr_data  = (state_q == CLEAR) ? '0 : s2_data_q;

endmodule
